// File: rtl/decimator_mc.sv
// Multi-channel gated decimator: synchronises CH modulated bitstreams and counts
// level-high cycles or rising edges over a shared programmable window of RATIO clocks.
module decimator_mc #(
  parameter int unsigned W           = 16,
  parameter int unsigned CH          = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            EN,
  input  logic [CH-1:0]   MODE,
  input  logic [W-1:0]    RATIO,
  input  logic [CH-1:0]   VMOD,
  output logic [CH*W-1:0] Q,
  output logic            Q_VALID,
  output logic [W-1:0]    timer,
  output logic [CH*W-1:0] count
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic [SYNC_STAGES-1:0][CH-1:0]    sync_q, sync_d;
  logic [CH-1:0]                     hist_q, hist_d;
  logic [CH-1:0]                     mode_sh_q, mode_sh_d;
  logic [W-1:0]                      ratio_sh_q, ratio_sh_d;
  logic [W-1:0]                      timer_q, timer_d;
  logic [CH*W-1:0]                   count_q, count_d;
  logic [CH*W-1:0]                   q_q, q_d;
  logic                              q_valid_q, q_valid_d;

  logic [CH-1:0] sync_s;
  logic [CH-1:0] evt;
  logic [W-1:0]  win_len;
  logic          win_last;

  // Synchroniser shifts every clock regardless of EN; history tracks the synced bit.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], VMOD};
  assign sync_s = sync_q[SYNC_STAGES-1];
  assign hist_d = sync_s;
  assign evt    = (mode_sh_q & sync_s & ~hist_q) | (~mode_sh_q & sync_s);

  // Windows shorter than 2 clocks are widened to 2.
  assign win_len  = (ratio_sh_q < W'(2)) ? W'(2) : ratio_sh_q;
  assign win_last = (timer_q == (win_len - W'(1)));

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q     <= '0;
      hist_q     <= '0;
      mode_sh_q  <= '0;
      ratio_sh_q <= '0;
      timer_q    <= '0;
      count_q    <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      mode_sh_q  <= mode_sh_d;
      ratio_sh_q <= ratio_sh_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (EN) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Counter, timer and result update
  always_comb begin
    timer_d    = timer_q;
    count_d    = count_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    ratio_sh_d = ratio_sh_q;
    mode_sh_d  = mode_sh_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        count_d = '0;
        if (EN) begin
          ratio_sh_d = RATIO;
          mode_sh_d  = MODE;
        end
      end
      RUN: begin
        if (EN) begin
          if (win_last) begin
            for (int c = 0; c < int'(CH); c++) begin
              q_d[c*W +: W] = count_q[c*W +: W] + W'(evt[c]);
            end
            count_d    = '0;
            timer_d    = '0;
            q_valid_d  = 1'b1;
            ratio_sh_d = RATIO;
            mode_sh_d  = MODE;
          end else begin
            for (int c = 0; c < int'(CH); c++) begin
              count_d[c*W +: W] = count_q[c*W +: W] + W'(evt[c]);
            end
            timer_d = timer_q + W'(1);
          end
        end
      end
      default: begin
        timer_d = '0;
        count_d = '0;
      end
    endcase
  end

  assign Q       = q_q;
  assign Q_VALID = q_valid_q;
  assign timer   = timer_q;
  assign count   = count_q;

endmodule

// File: tb/tb_decimator_mc.sv
// Directed, table-driven bench for decimator_mc with hand sequences for
// mid-window RATIO change, EN freeze, window-length limits and async reset.
module tb_decimator_mc;

  localparam int unsigned W  = 16;
  localparam int unsigned CH = 2;

  logic            CLK;
  logic            RST_N;
  logic            EN;
  logic [CH-1:0]   MODE;
  logic [W-1:0]    RATIO;
  logic [CH-1:0]   VMOD;
  logic [CH*W-1:0] Q;
  logic            Q_VALID;
  logic [W-1:0]    timer;
  logic [CH*W-1:0] count;

  decimator_mc #(.W(W), .CH(CH), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .RATIO(RATIO), .VMOD(VMOD),
    .Q(Q), .Q_VALID(Q_VALID), .timer(timer), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // VMOD pattern generator: period 0 means constant level (hi != 0 -> 1).
  int per [CH];
  int hi  [CH];
  int cyc;
  initial begin
    cyc = 0;
    VMOD = '0;
  end
  always @(negedge CLK) begin
    cyc = cyc + 1;
    for (int c = 0; c < int'(CH); c++) begin
      if (per[c] == 0) VMOD[c] = (hi[c] != 0);
      else             VMOD[c] = ((cyc % per[c]) < hi[c]);
    end
  end

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait for Q_VALID within a budget; n = ticks taken, tmax = largest timer seen before it.
  task automatic wait_valid(input string name, input int budget, output int n, output int tmax);
    bit got;
    got  = 1'b0;
    n    = 0;
    tmax = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      n = n + 1;
      if (Q_VALID) begin
        got = 1'b1;
        break;
      end
      if (int'(timer) > tmax) tmax = int'(timer);
    end
    if (!got) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: timeout after %0d clocks waiting for Q_VALID", name, budget);
    end
  endtask

  // Reset, let the synchronisers fill with EN low, then start counting.
  task automatic restart(input logic [1:0] m, input logic [15:0] r,
                         input int p0, input int h0, input int p1, input int h1);
    per[0] = p0; hi[0] = h0; per[1] = p1; hi[1] = h1;
    EN = 1'b0;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    MODE  = m;
    RATIO = r;
    EN    = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] ratio;
    int          p0, h0, p1, h1;
    logic [15:0] exp0, exp1;
    int          len;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n, tmax;
    bit ok;
    checks = 0;
    errors = 0;
    per[0] = 0; hi[0] = 0; per[1] = 0; hi[1] = 0;
    EN = 1'b0; MODE = '0; RATIO = '0;

    vecs[0] = '{2'b00, 16'd6,  6, 3, 0, 0, 16'd3, 16'd0,  6};
    vecs[1] = '{2'b11, 16'd12, 4, 2, 6, 3, 16'd3, 16'd2,  12};
    vecs[2] = '{2'b10, 16'd8,  4, 1, 2, 1, 16'd2, 16'd4,  8};
    vecs[3] = '{2'b01, 16'd10, 5, 2, 0, 1, 16'd2, 16'd10, 10};
    vecs[4] = '{2'b00, 16'd1,  0, 1, 2, 1, 16'd2, 16'd1,  2};
    vecs[5] = '{2'b00, 16'd0,  0, 1, 0, 0, 16'd2, 16'd0,  2};
    vecs[6] = '{2'b11, 16'd2,  2, 1, 0, 1, 16'd1, 16'd0,  2};

    // Reset state, asynchronous and mid-cycle
    RST_N = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_q",       Q,               32'd0);
    check("rst_count",   count,           32'd0);
    check("rst_timer",   32'(timer),      32'd0);
    check("rst_qvalid",  32'(Q_VALID),    32'd0);

    // Table-driven windows
    foreach (vecs[v]) begin
      restart(vecs[v].mode, vecs[v].ratio, vecs[v].p0, vecs[v].h0, vecs[v].p1, vecs[v].h1);
      for (int w = 0; w < 3; w++) begin
        wait_valid($sformatf("v%0d_w%0d", v, w), 200, n, tmax);
        check($sformatf("v%0d_w%0d_interval", v, w), 32'(n), 32'(vecs[v].len + ((w == 0) ? 1 : 0)));
        check($sformatf("v%0d_w%0d_q0", v, w), 32'(Q[15:0]),  32'(vecs[v].exp0));
        check($sformatf("v%0d_w%0d_q1", v, w), 32'(Q[31:16]), 32'(vecs[v].exp1));
        check($sformatf("v%0d_w%0d_timer", v, w), 32'(timer), 32'd0);
        check($sformatf("v%0d_w%0d_tmax", v, w), 32'(tmax), 32'(vecs[v].len - 1));
      end
    end

    // Mid-window RATIO change only takes effect at the next boundary
    restart(2'b00, 16'd6, 6, 3, 0, 0);
    wait_valid("ratchg_w0", 200, n, tmax);
    tick();
    tick();
    check("ratchg_timer2", 32'(timer), 32'd2);
    RATIO = 16'd10;
    wait_valid("ratchg_w1", 200, n, tmax);
    check("ratchg_w1_rest", 32'(n), 32'd4);
    wait_valid("ratchg_w2", 200, n, tmax);
    check("ratchg_w2_len",  32'(n), 32'd10);
    check("ratchg_w2_tmax", 32'(tmax), 32'd9);

    // EN freeze for 3 clocks at timer 3
    restart(2'b00, 16'd8, 0, 1, 0, 0);
    wait_valid("freeze_w0", 200, n, tmax);
    for (int i = 0; i < 3; i++) tick();
    check("freeze_timer3", 32'(timer), 32'd3);
    EN = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (timer !== 16'd3 || Q_VALID !== 1'b0) ok = 1'b0;
    end
    check("freeze_hold", 32'(ok), 32'd1);
    EN = 1'b1;
    wait_valid("freeze_w1", 200, n, tmax);
    check("freeze_rest", 32'(n), 32'd5);
    check("freeze_q0", 32'(Q[15:0]), 32'd8);

    // Longest window, then RATIO 1 and 0 both give a 2-clock window
    restart(2'b00, 16'hFFFF, 0, 1, 0, 0);
    tick();
    RATIO = 16'd1;
    wait_valid("max_w0", 70000, n, tmax);
    check("max_len", 32'(n), 32'hFFFF);
    check("max_q0", 32'(Q[15:0]), 32'hFFFF);
    RATIO = 16'd0;
    wait_valid("r1_w", 200, n, tmax);
    check("r1_len", 32'(n), 32'd2);
    check("r1_q0", 32'(Q[15:0]), 32'd2);
    wait_valid("r0_w", 200, n, tmax);
    check("r0_len", 32'(n), 32'd2);
    check("r0_q0", 32'(Q[15:0]), 32'd2);

    // Asynchronous reset mid-window, then restart straight from reset release
    restart(2'b00, 16'd8, 0, 1, 0, 0);
    wait_valid("arst_w0", 200, n, tmax);
    for (int i = 0; i < 4; i++) tick();
    check("arst_timer4", 32'(timer), 32'd4);
    check("arst_count4", 32'(count[15:0]), 32'd4);
    RST_N = 1'b0;
    #1;
    check("arst_q",      Q,            32'd0);
    check("arst_count",  count,        32'd0);
    check("arst_timer",  32'(timer),   32'd0);
    check("arst_qvalid", 32'(Q_VALID), 32'd0);
    tick();
    RST_N = 1'b1;
    EN    = 1'b1;
    wait_valid("arst_w1", 200, n, tmax);
    check("arst_first_len", 32'(n), 32'd9);
    check("arst_first_q0",  32'(Q[15:0]), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decimator_mc.md
Name: decimator_mc

Overview:
- Parametrised multi-channel successor to the 16-bit single-channel decimator.
- Each VMOD input is a 1-bit modulated stream. It is synchronised, then counted over a programmable gate window of RATIO clocks.
- Per channel, MODE selects level counting (high cycles, duty measurement) or rising-edge counting (frequency measurement).
- Sits between the modulator front end and the readout logic. Outputs a registered result with a one-cycle valid strobe per window.

Parameters:
- W, 16, width of timer, counters, RATIO and each result word.
- CH, 2, number of independent VMOD channels sharing one gate timer.
- SYNC_STAGES, 2, synchroniser flops on each VMOD bit (minimum 2).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  count enable; low freezes the window.
- MODE  in  CH  per-channel mode: 0 = level count, 1 = rising-edge count.
- RATIO  in  W  gate window length in clocks.
- VMOD  in  CH  asynchronous modulated bitstreams.
- Q  out  CH*W  latched result; channel c is Q[c*W +: W].
- Q_VALID  out  1  one-cycle pulse when Q updates.
- timer  out  W  current window position.
- count  out  CH*W  live per-channel accumulators, same packing as Q.

Behaviour:
- Reset (RST_N low, any time, including mid-window):
  - Q, count, timer, Q_VALID, synchroniser flops, edge-history flops and shadow registers go to 0.
  - FSM goes to IDLE.
  - Effect is immediate (asynchronous). Release is sampled on the next CLK edge.
- Synchroniser: VMOD[c] passes through SYNC_STAGES flops giving s[c], plus one history flop p[c].
  - Level event = s[c].
  - Edge event = s[c] & ~p[c].
  - VMOD-to-event latency = SYNC_STAGES clocks.
- Window length L = shadow RATIO. A RATIO value of 0 or 1 is treated as L = 2.
- FSM states: IDLE, RUN.
  - IDLE: timer = 0, count = 0. On the first cycle with EN = 1, latch RATIO and MODE into shadow registers and go to RUN. No sample is taken that cycle.
  - RUN, EN = 1: each channel adds its event bit (per its shadow MODE bit) to count. timer increments.
  - RUN, end of window (timer == L-1 with EN = 1):
    - Q[c] <= count[c] + event[c] (the last sample is included).
    - Q_VALID <= 1 on the following cycle only.
    - count <= 0 and timer <= 0.
    - RATIO and MODE are re-latched into the shadow registers.
    - FSM stays in RUN, so windows are back-to-back with no dead cycle.
  - RUN, EN = 0: timer, count and the synchroniser output are frozen for counting purposes. The synchroniser itself keeps clocking and p[c] keeps updating, so an edge during EN = 0 is not counted. Q holds. Q_VALID = 0.
- Changes to RATIO or MODE mid-window are ignored until the next window boundary.
- Arithmetic:
  - count is W bits unsigned.
  - Overflow is impossible because L ≤ 2^W-1 and each cycle adds at most 1.
  - Maximum result is L in level mode and ceil(L/2) in edge mode.
- Channels are fully independent except for the shared timer, EN and window boundary.
- Q_VALID never asserts in IDLE or before the first full window completes.

Test Plan:
1. CH = 2, MODE = 2'b00, RATIO = 6, EN = 1. VMOD[0] square wave, 3 clocks high / 3 low. VMOD[1] = 0. -> Q_VALID every 6 clocks, Q[15:0] = 3, Q[31:16] = 0, timer cycles 0..5.
2. MODE = 2'b11, RATIO = 12. VMOD[0] period 4 clocks, VMOD[1] period 6 clocks. -> Q[15:0] = 3, Q[31:16] = 2 every window.
3. RATIO = 6 running; write RATIO = 10 at timer = 2. -> current window still ends at timer = 5; next Q_VALID comes 10 clocks later; timer then reaches 9.
4. EN low for 3 clocks at timer = 3, with VMOD[0] = 1 constant, MODE = 0, RATIO = 8. -> timer holds 3, Q_VALID is delayed 3 clocks, Q[15:0] = 8 (no counts during the freeze).
5. VMOD[0] = 1 constant, MODE = 0. RATIO = 0xFFFF -> Q[15:0] = 0xFFFF. Then RATIO = 1 -> window of 2, Q[15:0] = 2. Then RATIO = 0 -> Q[15:0] = 2.
6. Assert RST_N = 0 at timer = 4 with count[15:0] = 4. -> all outputs are 0 in the same time step without a clock edge. After release with EN = 1, there is one IDLE cycle, then first Q_VALID after L clocks.
